// File: rtl/data_mem_responder_pkg.sv
// Shared types and defaults for the data-memory responder.
// Holds the FSM state encoding, default geometry/latency and the
// address fault check used by the responder.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int DMEM_DEPTH_WORDS_DEFAULT = 1024;
  localparam int DMEM_LATENCY_DEFAULT     = 2;

  // Wide enough for the largest legal latency (15).
  localparam int DMEM_CNT_W = 4;

  // A request faults when it is not word aligned or when its full 30-bit
  // word index lies beyond the array. The index is never truncated, so
  // stray upper address bits cannot alias onto a low word.
  function automatic logic dmem_addr_fault(input logic [31:0] addr,
                                           input int unsigned depth);
    logic [31:0] idx;
    idx = {2'b00, addr[31:2]};
    return (addr[1:0] != 2'b00) || (idx >= depth);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// LSU <-> data memory request/response bundle.
// master = LSU side, slave = responder side.
interface data_mem_responder_if;

  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  modport master (
    output data_req_i,
    output data_we_i,
    output data_be_i,
    output data_addr_i,
    output data_wdata_i,
    input  data_gnt_o,
    input  data_rvalid_o,
    input  data_rdata_o,
    input  data_err_o
  );

  modport slave (
    input  data_req_i,
    input  data_we_i,
    input  data_be_i,
    input  data_addr_i,
    input  data_wdata_i,
    output data_gnt_o,
    output data_rvalid_o,
    output data_rdata_o,
    output data_err_o
  );

endinterface

// File: rtl/data_mem_responder_dmem_array.sv
// Word-organised data array: synchronous byte-masked write and a
// registered read port. Contents are intentionally never reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clock,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Byte-lane masked write; only enabled lanes change.
  always_ff @(posedge clock) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Read register loads only on a read strobe and otherwise holds its word.
  always_ff @(posedge clock) begin
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for an LSU req/gnt/rvalid bus.
// One request in flight: IDLE accepts, WAIT counts out the latency,
// RESP presents a single-cycle response, then back to IDLE.
// Stores commit to the array on the accepting edge; loads read the array
// on the accepting edge and the word is held until RESP.
// Build option: define DMEM_BYTE_ENABLE_EN to make stores honour
// data_be_i; otherwise every store writes the full word.
module data_mem_responder
  import core_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS_DEFAULT,
  parameter int LATENCY     = DMEM_LATENCY_DEFAULT
) (
  input logic                 clock,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [DMEM_CNT_W-1:0] CNT_INIT = DMEM_CNT_W'(LATENCY - 1);

  dmem_state_t           state_q, state_d;
  logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
  logic                  gnt_q;
  logic                  we_q;
  logic                  err_q;

  logic                  accept;
  logic                  fault;
  logic                  wr_en;
  logic                  rd_en;
  logic [3:0]            be_eff;
  logic [AW-1:0]         widx;
  logic [31:0]           arr_rdata;
  logic                  in_resp;

  // gnt comes from a register, so acceptance never depends on req
  // combinationally; gnt_q is only ever high while state_q is IDLE.
  assign accept = gnt_q & bus.data_req_i;
  assign fault  = dmem_addr_fault(bus.data_addr_i, DEPTH_WORDS);
  assign widx   = bus.data_addr_i[AW+1:2];
  assign wr_en  = accept & bus.data_we_i & ~fault;
  assign rd_en  = accept & ~bus.data_we_i & ~fault;

`ifdef DMEM_BYTE_ENABLE_EN
  assign be_eff = bus.data_be_i;
`else
  // All four lanes are forced on; byte enables do not affect this build.
  assign be_eff = bus.data_be_i | 4'hF;
`endif

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clock   (clock),
    .we_i    (wr_en),
    .be_i    (be_eff),
    .re_i    (rd_en),
    .addr_i  (widx),
    .wdata_i (bus.data_wdata_i),
    .rdata_o (arr_rdata)
  );

  // Next-state and latency counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY <= 1) begin
            state_d = RESP;
            cnt_d   = '0;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= DMEM_CNT_W'(1)) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - DMEM_CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and grant registers; grant stays low during reset and
  // rises on the first edge after release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= (state_d == IDLE);
    end
  end

  // Capture the response kind of the accepted request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      we_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (accept) begin
      we_q  <= bus.data_we_i;
      err_q <= fault;
    end
  end

  // Response outputs are gated by RESP so they read as zero at all other
  // times, including immediately on reset.
  assign in_resp           = (state_q == RESP);
  assign bus.data_gnt_o    = gnt_q;
  assign bus.data_rvalid_o = in_resp;
  assign bus.data_err_o    = in_resp & err_q;
  assign bus.data_rdata_o  = (in_resp && !we_q && !err_q) ? arr_rdata : 32'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance at LATENCY=2 for
// functional vectors and one at LATENCY=1 for back-to-back throughput.
module tb_data_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_tmo = 0;
  bit   done  = 1'b0;
  bit   gchk0 = 1'b0;
  bit   gchk1 = 1'b0;
  logic gexp0 = 1'b0;
  logic gexp1 = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] be_exp;

  data_mem_responder_if bus0();
  data_mem_responder_if bus1();

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut_l2 (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus0)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut_l1 (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void mon(input bit d, input logic rv, input logic [31:0] rd,
                              input logic er, input logic g, input bit gc,
                              input logic ge);
    exp_t e;
    bit   empty;
    if (gc) chk(d ? "gnt_l1" : "gnt_l2", 32'(g), 32'(ge));
    if (rv) begin
      empty = d ? (q1.size() == 0) : (q0.size() == 0);
      if (empty) begin
        chk(d ? "unexpected_rvalid_l1" : "unexpected_rvalid_l2", 32'(rv), 32'h0);
      end else begin
        if (d) e = q1.pop_front();
        else   e = q0.pop_front();
        chk(d ? "rdata_l1" : "rdata_l2", rd, e.rdata);
        chk(d ? "err_l1" : "err_l2", 32'(er), 32'(e.err));
        chk(d ? "rvalid_cycle_l1" : "rvalid_cycle_l2", 32'(cyc), 32'(e.cyc));
      end
    end else begin
      chk(d ? "idle_rdata_l1" : "idle_rdata_l2", rd, 32'h0);
      chk(d ? "idle_err_l1" : "idle_err_l2", 32'(er), 32'h0);
    end
  endfunction

  // Monitor: all comparisons and the summary live in this one process.
  always @(negedge clk) begin
    if (!done) begin
      mon(1'b0, bus0.data_rvalid_o, bus0.data_rdata_o, bus0.data_err_o,
          bus0.data_gnt_o, gchk0, gexp0);
      mon(1'b1, bus1.data_rvalid_o, bus1.data_rdata_o, bus1.data_err_o,
          bus1.data_gnt_o, gchk1, gexp1);
    end else begin
      chk("timeouts", 32'(n_tmo), 32'h0);
      chk("pending_l2", 32'(q0.size()), 32'h0);
      chk("pending_l1", 32'(q1.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
    end
  end

  task automatic drive(input bit d, input logic req, input logic we,
                       input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd);
    if (!d) begin
      bus0.data_req_i = req; bus0.data_we_i = we; bus0.data_be_i = be;
      bus0.data_addr_i = addr; bus0.data_wdata_i = wd;
    end else begin
      bus1.data_req_i = req; bus1.data_we_i = we; bus1.data_be_i = be;
      bus1.data_addr_i = addr; bus1.data_wdata_i = wd;
    end
  endtask

  task automatic issue(input bit d, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input bit push);
    exp_t e;
    bit   ok;
    logic g;
    @(negedge clk);
    drive(d, 1'b1, we, be, addr, wd);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      g = d ? bus1.data_gnt_o : bus0.data_gnt_o;
      if (g) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      e.rdata = er;
      e.err   = ee;
      e.cyc   = cyc + (d ? 1 : 2);
      if (push) begin
        if (d) q1.push_back(e);
        else   q0.push_back(e);
      end
      @(posedge clk);
      #1;
    end else begin
      n_tmo++;
    end
    drive(d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    gexp0 = 1'b0; gexp1 = 1'b0;
    gchk0 = 1'b1; gchk1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 gexp0 = 1'b1; gexp1 = 1'b1;
    @(posedge clk);
    #1 gchk0 = 1'b0; gchk1 = 1'b0;
  endtask

  initial begin
    bit ok;
    bit acc;
    int nacc;
`ifdef DMEM_BYTE_ENABLE_EN
    be_exp = 32'h11BB33DD;
`else
    be_exp = 32'hAABBCCDD;
`endif
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    do_reset();

    // Basic store/load and faults on the LATENCY=2 instance.
    issue(1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    issue(1'b0, 1'b0, 4'hF, 32'h13, 32'h0, 32'h0, 1'b1, 1'b1);
    issue(1'b0, 1'b1, 4'hF, 32'h12, 32'h12345678, 32'h0, 1'b1, 1'b1);
    issue(1'b0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    issue(1'b0, 1'b1, 4'hF, 32'h0, 32'h0BADF00D, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
    issue(1'b0, 1'b1, 4'hF, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
    issue(1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 32'h0BADF00D, 1'b0, 1'b1);
    issue(1'b0, 1'b1, 4'hF, 32'hFFC, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 1'b0, 4'hF, 32'hFFC, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);

    // Byte-lane store.
    issue(1'b0, 1'b1, 4'hF, 32'h20, 32'h11223344, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 1'b0, 4'hF, 32'h20, 32'h0, be_exp, 1'b0, 1'b1);

    // Reset while the store is in WAIT: its response is dropped, data kept.
    issue(1'b0, 1'b1, 4'hF, 32'h40, 32'h5, 32'h0, 1'b0, 1'b0);
    do_reset();
    issue(1'b0, 1'b0, 4'hF, 32'h40, 32'h0, 32'h5, 1'b0, 1'b1);

    // Preload the LATENCY=1 instance.
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b1, 4'hF, 32'(4 * i), 32'hA1A10000 + 32'(i), 32'h0, 1'b0, 1'b1);
    end

    // Back-to-back loads with req held high.
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus1.data_gnt_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) n_tmo++;
    nacc = 0;
    drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
    for (int j = 0; j < 8; j++) begin
      acc = bus1.data_gnt_o && (nacc < 4);
      if (acc) q1.push_back('{rdata: 32'hA1A10000 + 32'(nacc), err: 1'b0, cyc: cyc + 1});
      @(posedge clk);
      #1;
      if (acc) begin
        nacc++;
        if (nacc == 4) drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        else           drive(1'b1, 1'b1, 1'b0, 4'hF, 32'(4 * nacc), 32'h0);
      end
      gchk1 = 1'b1;
      gexp1 = (j % 2 == 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1 gchk1 = 1'b0;
    if (nacc != 4) n_tmo++;
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    repeat (10) @(posedge clk);
    #1 done = 1'b1;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameters, one per line:
  DEPTH_WORDS, 1024, number of 32-bit words in the data array (power of two).
  LATENCY, 2, cycles from accepting edge to response (legal 1..15).
REQ-002 SHALL have ports, one per line:
  clock  input  1  single clock, rising edge.
  reset  input  1  asynchronous, active-low reset.
  data_req_i  input  1  LSU request valid.
  data_we_i  input  1  1 = store, 0 = load.
  data_be_i  input  4  byte enables, bit n = byte lane n.
  data_addr_i  input  32  byte address.
  data_wdata_i  input  32  store data.
  data_gnt_o  output  1  responder can accept a request this cycle.
  data_rvalid_o  output  1  one-cycle response strobe.
  data_rdata_o  output  32  load data, valid with rvalid.
  data_err_o  output  1  request faulted, valid with rvalid.
REQ-003 SHALL drive data_gnt_o from state only, never combinationally from data_req_i, so the LSU's req/gnt dependency forms no loop.

Function
REQ-004 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; gnt_o = 1 only in IDLE.
REQ-005 Request SHALL be accepted on a rising edge where state = IDLE and data_req_i = 1; address, we, be and wdata are captured at that edge.
REQ-006 On acceptance SHALL enter WAIT with counter = LATENCY-1; when LATENCY = 1, SHALL go directly to RESP.
REQ-007 In WAIT, counter SHALL decrement each edge; at counter = 1 the next state SHALL be RESP.
REQ-008 Result: data_rvalid_o high for exactly one cycle, the LATENCY-th cycle after the accepting edge; state then returns to IDLE.
REQ-009 Store: array write SHALL commit at the accepting edge.
  On response: data_rdata_o = 0, data_err_o = 0.
REQ-010 Load: array word SHALL be read at the accepting edge and held in a register until RESP.
REQ-011 Fault: SHALL fault when data_addr_i[1:0] != 0 or word index >= DEPTH_WORDS.
  No array write occurs.
  Response: data_err_o = 1, data_rdata_o = 0.
REQ-012 Outside RESP, data_rvalid_o, data_err_o and data_rdata_o SHALL be 0.
REQ-013 Word index SHALL be data_addr_i[31:2]; upper bits beyond log2(DEPTH_WORDS) SHALL be range-checked, never truncated.
REQ-014 Requests while gnt_o = 0 SHALL be ignored with no side effect; the LSU must hold them.
REQ-015 A new request SHALL be accepted no earlier than the cycle after RESP (max throughput: one per LATENCY+1 cycles).

Reset
REQ-016 On reset = 0, SHALL immediately set state = IDLE, counter = 0 and all outputs to 0, except gnt_o, which SHALL be 0 while reset is asserted and 1 from the first cycle after release.
REQ-017 Reset mid-transaction SHALL drop the pending response.
  A store already committed at its accepting edge stays written.
REQ-018 The array contents SHALL NOT be reset.

Configuration
REQ-019 Macro DMEM_BYTE_ENABLE_EN defined: stores SHALL write only byte lanes with data_be_i[n] = 1.
  Loads always return the full word.
REQ-020 Macro undefined: data_be_i SHALL be ignored and every store SHALL write all four bytes.

Structure
REQ-021 CORE_PKG SHALL hold the dmem_state_t enum (IDLE, WAIT, RESP) and the constants DMEM_DEPTH_WORDS_DEFAULT and DMEM_LATENCY_DEFAULT.
REQ-022 Storage SHALL be a sub-module dmem_array: synchronous write with per-byte enables and a registered read; the FSM stays in data_mem_responder.

Verification
REQ-023 Store/load, LATENCY = 2:
  Store 0xDEADBEEF to 0x10 -> rvalid 2 cycles after accept, err = 0.
  Load 0x10 -> rdata = 0xDEADBEEF.
REQ-024 Misaligned load 0x13 -> rvalid with err = 1, rdata = 0.
  Out-of-range store to 4*DEPTH_WORDS -> err = 1 and word 0 unchanged.
REQ-025 Byte enables, DMEM_BYTE_ENABLE_EN defined:
  Store 0x11223344 to 0x20, then store 0xAABBCCDD with be = 0b0101 -> load 0x20 returns 0x11BB33DD.
  Same sequence with the macro undefined -> load returns 0xAABBCCDD.
REQ-026 Back-to-back, LATENCY = 1, data_req_i held high for 4 loads:
  gnt_o pattern 1,0,1,0,...; rvalid lands in the cycle after each accept.
  No request is lost or duplicated.
REQ-027 Reset during WAIT after a store to 0x40 of 0x5 -> no rvalid; gnt_o = 1 after release.
  A subsequent load of 0x40 returns 0x5.
